rtx_multi: RTL and testbench
============================

RTX_MULTI -- requirements
Module: rtx_multi

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WIDTH, 1280, pixels per row.
- HEIGHT, 720, rows per frame.
- NUM_LANES, 4, number of external ray_tracer lanes; power of two, 1..8.
- R_BITS / G_BITS / B_BITS, 5 / 6 / 5, output channel widths.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, asynchronous, active-high reset.
- start, in, 1, one-cycle pulse that begins a frame.
- lane_issue, out, NUM_LANES, one-hot pulse that issues the pixel to that lane.
- issue_h, out, 11, column of the issued pixel.
- issue_v, out, 10, row of the issued pixel.
- lane_done, in, NUM_LANES, per-lane completion pulse.
- lane_color, in, NUM_LANES x fp24_color, per-lane result; valid while lane_done is high.
- rtx_pixel, out, B_BITS+G_BITS+R_BITS, packed {b,g,r}, with r in the LSBs.
- pixel_h, out, 11, column of the retired pixel.
- pixel_v, out, 10, row of the retired pixel.
- pixel_valid, out, 1, one-cycle pulse; pixel is strictly raster order.
- frame_done, out, 1, one-cycle pulse after the last pixel retires.
- busy, out, 1, high from the accepted start until frame_done.

Function
REQ-003 The state machine SHALL have three states:
- IDLE -> RUN on start.
- RUN -> DRAIN when the last pixel is issued.
- DRAIN -> IDLE in the cycle frame_done pulses.
- start outside IDLE SHALL be ignored.
REQ-004 The issue counter SHALL scan raster order.
- (h,v) starts at (0,0); h wraps at WIDTH-1 with v+1.
- Issue stops after (WIDTH-1,HEIGHT-1).
REQ-005 In RUN, at most one lane SHALL be issued per cycle.
- Target: the lowest-index lane that has no outstanding pixel.
- Condition: outstanding count < NUM_LANES.
REQ-006 Each issue SHALL allocate reorder-buffer (ROB) slot seq mod NUM_LANES.
- seq is the pixel sequence number.
- The lane records its slot; the ROB has NUM_LANES entries.
REQ-007 On lane_done[i] for an outstanding lane i:
- Write lane_color[i] into lane i's slot and mark it valid.
- Clear lane i's outstanding flag; the lane is issuable the next cycle.
- Any number of lanes MAY complete in the same cycle; all SHALL be captured.
REQ-008 lane_done for a non-outstanding lane, including the issue cycle itself, SHALL be ignored.
REQ-009 Retire: each cycle, if the head slot is valid:
- Retire it and clear its valid bit.
- Advance the head; at most one retire per cycle.
REQ-010 Retire latency: capture at cycle t with the slot at head gives pixel_valid at t+3.
- t+1: retire.
- t+2: clip stage.
- t+3: convert stage and output register.
REQ-011 Channel conversion, per channel of N bits:
- Clip fp24 to [0, 1.0], where 1.0 = 24'h3f0000; negatives give 0.
- Output = floor(x * 2^N), saturated to 2^N-1.
REQ-012 pixel_h and pixel_v SHALL travel with the ROB entry and match the issued coordinates.
REQ-013 frame_done SHALL pulse the cycle after pixel_valid for (WIDTH-1,HEIGHT-1).
- busy falls in the same cycle as frame_done.
REQ-014 A full ROB or no idle lane SHALL stall issue with no loss.
- issue_h and issue_v SHALL hold.
REQ-015 All counters SHALL be sized by $clog2 of their parameters.
- No overflow for the default parameters.

Reset
REQ-016 rst SHALL immediately clear all of the following, at any time including mid-frame:
- State = IDLE, and all outstanding flags, ROB valid bits and pointers.
- issue_h and issue_v = 0; lane_issue = 0.
- pixel_valid, frame_done and busy = 0; rtx_pixel, pixel_h and pixel_v = 0.
REQ-017 lane_done arriving after reset for pre-reset issues SHALL be ignored, per REQ-008.

Verification (WIDTH=4, HEIGHT=2, NUM_LANES=4, 5/6/5)
REQ-018 Single lane, fixed latency 5, all colors 24'h3f0000:
- 8 pixel_valid pulses in raster order, each rtx_pixel = 16'hFFFF.
- frame_done one cycle after the 8th pulse.
REQ-019 Out-of-order completion:
- Lanes 0..3 get pixels 0..3; done order 3,2,1,0 on consecutive cycles.
- No pixel_valid until lane 0 completes; then pixels 0..3 on 4 consecutive cycles.
REQ-020 Simultaneous completion:
- All 4 lanes assert lane_done in one cycle with r=24'h3e0000 (0.5), g=0, b=24'hbf0000 (-1.0).
- Each pixel: r=16, g=0, b=0 (rtx_pixel=16'h0010), over 4 consecutive cycles.
REQ-021 Stall and spurious completion:
- With lane_done held low, issue stops after 4 issues; issue_h=0, issue_v=1 hold.
- A spurious lane_done on an idle lane produces no output.
REQ-022 Reset and restart:
- Assert rst mid-frame with 2 outstanding: all outputs are 0 immediately.
- Late lane_done is ignored.
- A new start completes a clean 8-pixel frame.

Source files
------------

// File: rtl/rtx_multi.sv
// Frame scheduler for a pool of ray_tracer lanes: issues pixels in raster order,
// reorders out-of-order lane results, and converts fp24 colour to packed RGB.
module rtx_multi #(
  parameter int unsigned WIDTH     = 1280,
  parameter int unsigned HEIGHT    = 720,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned R_BITS    = 5,
  parameter int unsigned G_BITS    = 6,
  parameter int unsigned B_BITS    = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic [NUM_LANES-1:0]              lane_issue,
  output logic [10:0]                       issue_h,
  output logic [9:0]                        issue_v,
  input  logic [NUM_LANES-1:0]              lane_done,
  input  logic [NUM_LANES*72-1:0]           lane_color,
  output logic [B_BITS+G_BITS+R_BITS-1:0]   rtx_pixel,
  output logic [10:0]                       pixel_h,
  output logic [9:0]                        pixel_v,
  output logic                              pixel_valid,
  output logic                              frame_done,
  output logic                              busy
);

  localparam int unsigned HW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned VW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned SW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned OW = $clog2(NUM_LANES + 1);
  localparam int unsigned CW = 72;
  localparam logic [23:0] FP_ONE = 24'h3f0000;

  // fp24: sign[23], exponent[22:16] (bias 63), mantissa[15:0]
  typedef struct packed {
    logic [23:0] b;
    logic [23:0] g;
    logic [23:0] r;
  } color_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_d;
  logic                 start_go, issue_go, frame_done_d;
  logic [NUM_LANES-1:0] issue_oh, free_oh, done_acc, busy_lane;
  logic [HW-1:0]        dec_h;
  logic [VW-1:0]        dec_v;
  logic [SW-1:0]        tail, head;
  logic [OW-1:0]        occ;
  logic                 retire, dec_last, pixel_last;
  logic [SW-1:0]        lane_slot [NUM_LANES];

  logic [NUM_LANES-1:0] rob_valid;
  color_t               rob_color [NUM_LANES];
  logic [HW-1:0]        rob_h [NUM_LANES];
  logic [VW-1:0]        rob_v [NUM_LANES];

  logic                 s1_valid, s2_valid;
  color_t               s1_color, s2_color;
  logic [HW-1:0]        s1_h, s2_h;
  logic [VW-1:0]        s1_v, s2_v;
  logic [R_BITS-1:0]    cvt_r;
  logic [G_BITS-1:0]    cvt_g;
  logic [B_BITS-1:0]    cvt_b;

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (s == SW'(NUM_LANES - 1)) ? '0 : s + SW'(1);
  endfunction

  function automatic logic [23:0] fp_clip(input logic [23:0] x);
    if (x[23]) return 24'h0;
    if (x[22:16] >= 7'd63) return FP_ONE;
    return x;
  endfunction

  // floor(x * 2^n) for x already clipped to [0,1], saturated to 2^n-1 (n <= 8)
  function automatic logic [7:0] fp_unorm(input logic [23:0] x, input int unsigned n);
    logic [6:0]  e;
    logic [16:0] m;
    int unsigned amt;
    logic [7:0]  r;
    e   = x[22:16];
    m   = {1'b1, x[15:0]};
    r   = '0;
    amt = 32'd79 - 32'(e) - n;
    if (e >= 7'd63) r = 8'((32'd1 << n) - 32'd1);
    else if (e != 7'd0 && amt < 32'd17) r = 8'(m >> amt);
    return r;
  endfunction

  assign done_acc   = lane_done & busy_lane & ~lane_issue;
  assign retire     = rob_valid[head];
  assign dec_last   = (dec_h == HW'(WIDTH - 1)) && (dec_v == VW'(HEIGHT - 1));
  assign pixel_last = pixel_valid && (pixel_h == 11'(WIDTH - 1)) && (pixel_v == 10'(HEIGHT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, lowest free lane pick and issue decision
  always_comb begin
    state_d      = state;
    start_go     = 1'b0;
    issue_go     = 1'b0;
    issue_oh     = '0;
    frame_done_d = 1'b0;
    free_oh      = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (!busy_lane[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
    case (state)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          start_go = 1'b1;
        end
      end
      RUN: begin
        if (free_oh != '0 && occ < OW'(NUM_LANES)) begin
          issue_go = 1'b1;
          issue_oh = free_oh;
          if (dec_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pixel_last) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue counters, lane bookkeeping and ROB pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_issue <= '0;
      issue_h    <= '0;
      issue_v    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dec_h      <= '0;
      dec_v      <= '0;
      tail       <= '0;
      head       <= '0;
      occ        <= '0;
      busy_lane  <= '0;
      for (int i = 0; i < NUM_LANES; i++) lane_slot[i] <= '0;
    end else begin
      lane_issue <= issue_oh;
      issue_h    <= 11'(dec_h);
      issue_v    <= 10'(dec_v);
      frame_done <= frame_done_d;
      if (start_go)          busy <= 1'b1;
      else if (frame_done_d) busy <= 1'b0;
      busy_lane <= (busy_lane & ~done_acc) | issue_oh;
      occ       <= occ + OW'(issue_go) - OW'(retire);
      if (retire) head <= slot_inc(head);
      for (int i = 0; i < NUM_LANES; i++) begin
        if (issue_oh[i]) lane_slot[i] <= tail;
      end
      if (start_go) begin
        dec_h <= '0;
        dec_v <= '0;
        tail  <= '0;
        head  <= '0;
      end else if (issue_go) begin
        tail <= slot_inc(tail);
        if (dec_h == HW'(WIDTH - 1)) begin
          dec_h <= '0;
          dec_v <= (dec_v == VW'(HEIGHT - 1)) ? '0 : dec_v + VW'(1);
        end else begin
          dec_h <= dec_h + HW'(1);
        end
      end
    end
  end

  // Reorder buffer: coordinates written at issue, colour at lane completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rob_valid <= '0;
      for (int s = 0; s < NUM_LANES; s++) begin
        rob_color[s] <= '0;
        rob_h[s]     <= '0;
        rob_v[s]     <= '0;
      end
    end else begin
      if (retire) rob_valid[head] <= 1'b0;
      if (issue_go) begin
        rob_h[tail] <= dec_h;
        rob_v[tail] <= dec_v;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (done_acc[i]) begin
          rob_valid[lane_slot[i]] <= 1'b1;
          rob_color[lane_slot[i]] <= color_t'(lane_color[i*CW +: CW]);
        end
      end
    end
  end

  always_comb begin
    cvt_r = R_BITS'(fp_unorm(s2_color.r, R_BITS));
    cvt_g = G_BITS'(fp_unorm(s2_color.g, G_BITS));
    cvt_b = B_BITS'(fp_unorm(s2_color.b, B_BITS));
  end

  // Retire -> clip -> convert/output pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_color    <= '0;
      s1_h        <= '0;
      s1_v        <= '0;
      s2_valid    <= 1'b0;
      s2_color    <= '0;
      s2_h        <= '0;
      s2_v        <= '0;
      pixel_valid <= 1'b0;
      rtx_pixel   <= '0;
      pixel_h     <= '0;
      pixel_v     <= '0;
    end else begin
      s1_valid <= retire;
      if (retire) begin
        s1_color <= rob_color[head];
        s1_h     <= rob_h[head];
        s1_v     <= rob_v[head];
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_color <= {fp_clip(s1_color.b), fp_clip(s1_color.g), fp_clip(s1_color.r)};
        s2_h     <= s1_h;
        s2_v     <= s1_v;
      end
      pixel_valid <= s2_valid;
      if (s2_valid) begin
        rtx_pixel <= {cvt_b, cvt_g, cvt_r};
        pixel_h   <= 11'(s2_h);
        pixel_v   <= 10'(s2_v);
      end
    end
  end

endmodule

// File: tb/tb_rtx_multi.sv
// Scoreboard bench for rtx_multi on a 4x2 frame with 4 lanes and 5/6/5 output.
module tb_rtx_multi;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   lane_issue;
  logic [10:0]  issue_h;
  logic [9:0]   issue_v;
  logic [3:0]   lane_done;
  logic [287:0] lane_color;
  logic [15:0]  rtx_pixel;
  logic [10:0]  pixel_h;
  logic [9:0]   pixel_v;
  logic         pixel_valid;
  logic         frame_done;
  logic         busy;

  rtx_multi #(
    .WIDTH(4), .HEIGHT(2), .NUM_LANES(4), .R_BITS(5), .G_BITS(6), .B_BITS(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .lane_issue(lane_issue), .issue_h(issue_h), .issue_v(issue_v),
    .lane_done(lane_done), .lane_color(lane_color),
    .rtx_pixel(rtx_pixel), .pixel_h(pixel_h), .pixel_v(pixel_v),
    .pixel_valid(pixel_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [71:0] C_ONE   = {24'h3f0000, 24'h3f0000, 24'h3f0000};
  localparam logic [71:0] C_R100  = {24'h000000, 24'h000000, 24'h3f0000};
  localparam logic [71:0] C_R050  = {24'h000000, 24'h000000, 24'h3e0000};
  localparam logic [71:0] C_R025  = {24'h000000, 24'h000000, 24'h3d0000};
  localparam logic [71:0] C_R0125 = {24'h000000, 24'h000000, 24'h3c0000};
  localparam logic [71:0] C_MIX   = {24'hbf0000, 24'h000000, 24'h3e0000};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] sb [$];
  logic [15:0] pix_tab [8];
  int          issued_lane [8];
  int          cnt [4];
  int          lat;
  logic        done_on_issue;
  logic [71:0] auto_col;
  int          exp_idx;
  int          pv_count, fd_count, fd_cyc;
  int          pv_cyc [16];
  int          d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the scoreboard on every output pixel
  task automatic monitor();
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (pixel_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pixel: got pix=%h h=%0d v=%0d expected no pixel", rtx_pixel, pixel_h, pixel_v);
        end else begin
          e = sb.pop_front();
          if ({rtx_pixel, pixel_h, pixel_v} !== e) begin
            n_fail++;
            $display("FAIL pixel: got pix=%h h=%0d v=%0d expected pix=%h h=%0d v=%0d",
                     rtx_pixel, pixel_h, pixel_v, e[36:21], e[20:10], e[9:0]);
          end
        end
        if (pv_count < 16) pv_cyc[pv_count] = cyc;
        pv_count++;
      end
      if (frame_done === 1'b1) begin
        fd_count++;
        fd_cyc = cyc;
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_at_frame_done: got %b expected 0", busy);
        end
      end
    end
  endtask

  task automatic clear_stats();
    pv_count = 0;
    fd_count = 0;
    fd_cyc   = 0;
    exp_idx  = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  // One clock of lane modelling: manual dones, latency-driven dones, issue capture
  task automatic tick(input logic [3:0] man_done, input logic [71:0] man_col);
    @(posedge clk);
    #1;
    lane_done = man_done;
    for (int i = 0; i < 4; i++) begin
      if (man_done[i]) lane_color[i*72 +: 72] = man_col;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          lane_done[i] = 1'b1;
          lane_color[i*72 +: 72] = auto_col;
        end
      end
    end
    if (lane_issue != 4'b0) begin
      if (exp_idx >= 8) begin
        chk("extra_issue", 64'(exp_idx), 64'd7);
      end else begin
        chk("issue_onehot", 64'($onehot(lane_issue)), 64'd1);
        chk("issue_h", 64'(issue_h), 64'(exp_idx % 4));
        chk("issue_v", 64'(issue_v), 64'(exp_idx / 4));
        for (int i = 0; i < 4; i++) begin
          if (lane_issue[i]) begin
            issued_lane[exp_idx] = i;
            if (lat > 0) cnt[i] = lat;
            if (done_on_issue) begin
              lane_done[i] = 1'b1;
              lane_color[i*72 +: 72] = C_ONE;
            end
          end
        end
        sb.push_back({pix_tab[exp_idx], 11'(exp_idx % 4), 10'(exp_idx / 4)});
        exp_idx++;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    lane_done = 4'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget);
    int k;
    k = 0;
    while (exp_idx < n && k < budget) begin
      tick(4'b0, 72'b0);
      k++;
    end
    if (exp_idx < n) chk("issue_timeout", 64'(exp_idx), 64'(n));
  endtask

  task automatic wait_frame(input string name, input int budget);
    int k;
    k = 0;
    while (fd_count == 0 && k < budget) begin
      tick(4'b0, 72'b0);
      k++;
    end
    if (fd_count == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no frame_done expected one within %0d cycles", name, budget);
    end else begin
      tick(4'b0, 72'b0);
      tick(4'b0, 72'b0);
      chk({name, "_pixels"}, 64'(pv_count), 64'd8);
      chk({name, "_fd_gap"}, 64'(fd_cyc - pv_cyc[7]), 64'd1);
      chk({name, "_fd_count"}, 64'(fd_count), 64'd1);
      chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
      chk({name, "_busy_low"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    lane_done = 4'b0;
    lane_color = '0;
    lat = 0;
    done_on_issue = 1'b0;
    auto_col = C_ONE;
    clear_stats();
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_issue", 64'({lane_issue, issue_h, issue_v}), 64'd0);
    chk("reset_pixel", 64'({rtx_pixel, pixel_h, pixel_v, pixel_valid, frame_done, busy}), 64'd0);
    rst = 1'b0;

    // Fixed latency 5 on every lane, white pixels
    for (int i = 0; i < 8; i++) pix_tab[i] = 16'hFFFF;
    clear_stats();
    lat = 5;
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_frame("lat5", 400);

    // Out-of-order completion 3,2,1,0 with distinct red levels
    pix_tab[0] = 16'h001F; pix_tab[1] = 16'h0010;
    pix_tab[2] = 16'h0008; pix_tab[3] = 16'h0004;
    clear_stats();
    lat = 0;
    pulse_start();
    wait_issues(4, 20);
    repeat (5) tick(4'b0, 72'b0);
    chk("ooo_stall_count", 64'(exp_idx), 64'd4);
    for (int k = 0; k < 4; k++) chk("ooo_lane", 64'(issued_lane[k]), 64'(k));
    lat = 3;
    tick(4'b1000, C_R0125);
    tick(4'b0100, C_R025);
    tick(4'b0010, C_R050);
    chk("ooo_no_early_pixel", 64'(pv_count), 64'd0);
    tick(4'b0001, C_R100);
    d = cyc;
    wait_frame("ooo", 200);
    chk("ooo_first_latency", 64'(pv_cyc[0] - d), 64'd4);
    chk("ooo_consecutive", 64'(pv_cyc[3] - pv_cyc[0]), 64'd3);

    // All four lanes complete together: r=0.5, g=0, b=-1.0
    for (int i = 0; i < 8; i++) pix_tab[i] = (i < 4) ? 16'h0010 : 16'hFFFF;
    clear_stats();
    lat = 0;
    pulse_start();
    wait_issues(4, 20);
    repeat (2) tick(4'b0, 72'b0);
    lat = 2;
    tick(4'b1111, C_MIX);
    d = cyc;
    wait_frame("simul", 200);
    chk("simul_first_latency", 64'(pv_cyc[0] - d), 64'd4);
    chk("simul_consecutive", 64'(pv_cyc[3] - pv_cyc[0]), 64'd3);

    // Spurious completions while idle and in the issue cycle; stall hold
    for (int i = 0; i < 8; i++) pix_tab[i] = 16'hFFFF;
    clear_stats();
    tick(4'b1111, C_ONE);
    repeat (6) tick(4'b0, 72'b0);
    chk("idle_spurious", 64'(pv_count), 64'd0);
    lat = 0;
    done_on_issue = 1'b1;
    pulse_start();
    wait_issues(4, 20);
    repeat (6) tick(4'b0, 72'b0);
    done_on_issue = 1'b0;
    chk("stall_count", 64'(exp_idx), 64'd4);
    chk("stall_issue_h", 64'(issue_h), 64'd0);
    chk("stall_issue_v", 64'(issue_v), 64'd1);
    chk("stall_lane_issue", 64'(lane_issue), 64'd0);
    chk("stall_no_pixel", 64'(pv_count), 64'd0);
    lat = 2;
    tick(4'b1111, C_ONE);
    wait_frame("stall", 200);

    // Mid-frame reset with two outstanding, late completions, restart
    clear_stats();
    lat = 0;
    pulse_start();
    wait_issues(2, 20);
    rst = 1'b1;
    #1;
    chk("midrst_issue", 64'({lane_issue, issue_h, issue_v}), 64'd0);
    chk("midrst_pixel", 64'({rtx_pixel, pixel_h, pixel_v, pixel_valid, frame_done, busy}), 64'd0);
    clear_stats();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4'b0011, C_ONE);
    repeat (8) tick(4'b0, 72'b0);
    chk("late_done_pixels", 64'(pv_count), 64'd0);
    chk("late_done_busy", 64'(busy), 64'd0);
    lat = 4;
    pulse_start();
    wait_frame("restart", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
